// File: rtl/udcnt_mod.sv
// Up/down counter with programmable modulus, wrap or saturate at the range
// ends, clock-enable prescaler, synchronous clamped load and a one-cycle
// terminal-count flag. All state updates on the falling edge of clk.
module udcnt_mod #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX      = 2**N - 1,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         ud,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         tc
);

    localparam logic [N-1:0] MAX_V  = N'(MAX);
    localparam bit           SAT_EN = (SATURATE != 0);

    logic         step_c;
    logic [N-1:0] q_nxt;
    logic         tc_nxt;

    generate
        if (PRESCALE > 1) begin : g_pre
            localparam int unsigned    PW   = $clog2(PRESCALE);
            localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pre;
            logic [PW-1:0] pre_nxt;

            // Prescaler next state: cleared by load, advances on enable.
            always_comb begin
                pre_nxt = pre;
                if (load) begin
                    pre_nxt = '0;
                end else if (en) begin
                    if (pre == LAST) begin
                        pre_nxt = '0;
                    end else begin
                        pre_nxt = pre + PW'(1);
                    end
                end
            end

            // A count step fires on the enabled edge that wraps the prescaler.
            assign step_c = en && !load && (pre == LAST);

            // Prescaler register.
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pre <= '0;
                end else begin
                    pre <= pre_nxt;
                end
            end
        end else begin : g_nopre
            assign step_c = en && !load;
        end
    endgenerate

    // Count and terminal-count next state; load wins over stepping.
    always_comb begin
        q_nxt  = q;
        tc_nxt = 1'b0;
        if (load) begin
            q_nxt = (d > MAX_V) ? MAX_V : d;
        end else if (step_c) begin
            if (!ud) begin
                if (q == MAX_V) begin
                    tc_nxt = 1'b1;
                    q_nxt  = SAT_EN ? MAX_V : '0;
                end else begin
                    q_nxt = q + N'(1);
                end
            end else begin
                if (q == '0) begin
                    tc_nxt = 1'b1;
                    q_nxt  = SAT_EN ? '0 : MAX_V;
                end else begin
                    q_nxt = q - N'(1);
                end
            end
        end
    end

    // Output registers.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q  <= '0;
            tc <= 1'b0;
        end else begin
            q  <= q_nxt;
            tc <= tc_nxt;
        end
    end

endmodule

// File: tb/tb_udcnt_mod.sv
// Directed bench for udcnt_mod: three instances (wrap, saturate, prescale-3),
// all with N=4 and MAX=9, driven from shared inputs.
module tb_udcnt_mod;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       ud;
    logic       load;
    logic [3:0] d;
    logic [3:0] q_a, q_b, q_c;
    logic       tc_a, tc_b, tc_c;

    int tests  = 0;
    int failed = 0;

    udcnt_mod #(.N(4), .MAX(9), .SATURATE(0), .PRESCALE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .ud(ud), .load(load), .d(d),
        .q(q_a), .tc(tc_a)
    );

    udcnt_mod #(.N(4), .MAX(9), .SATURATE(1), .PRESCALE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .ud(ud), .load(load), .d(d),
        .q(q_b), .tc(tc_b)
    );

    udcnt_mod #(.N(4), .MAX(9), .SATURATE(0), .PRESCALE(3)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .ud(ud), .load(load), .d(d),
        .q(q_c), .tc(tc_c)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Single comparison point.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare all three instances' outputs.
    task automatic chk_all(input string tag,
                           input int qa, input int ta,
                           input int qb, input int tb,
                           input int qc, input int tcc);
        chk({tag, ".q_a"},  32'(q_a),  32'(qa));
        chk({tag, ".tc_a"}, 32'(tc_a), 32'(ta));
        chk({tag, ".q_b"},  32'(q_b),  32'(qb));
        chk({tag, ".tc_b"}, 32'(tc_b), 32'(tb));
        chk({tag, ".q_c"},  32'(q_c),  32'(qc));
        chk({tag, ".tc_c"}, 32'(tc_c), 32'(tcc));
    endtask

    // Advance to just after the next falling edge.
    task automatic edge_step();
        @(negedge clk);
        #1;
    endtask

    int exp_qa [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_ta [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int exp_qb [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
    int exp_tb [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    int exp_qc [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4};

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        ud    = 1'b0;
        load  = 1'b0;
        d     = 4'd0;

        // Reset state before any clock edge.
        #2;
        chk_all("reset_init", 0, 0, 0, 0, 0, 0);
        edge_step();
        chk_all("reset_held", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Count up 12 edges from 0.
        en = 1'b1;
        ud = 1'b0;
        for (int i = 0; i < 12; i++) begin
            edge_step();
            chk_all($sformatf("up_%0d", i + 1), exp_qa[i], exp_ta[i],
                    exp_qb[i], exp_tb[i], exp_qc[i], 0);
        end

        // Build q=7, prescaler=2 in the prescaled instance, then reset mid-cycle.
        en   = 1'b0;
        load = 1'b1;
        d    = 4'd7;
        edge_step();
        chk_all("load7", 7, 0, 7, 0, 7, 0);
        load = 1'b0;
        en   = 1'b1;
        edge_step();
        edge_step();
        chk_all("pre_2", 9, 0, 9, 0, 7, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0, 0);
        edge_step();
        chk_all("reset_hold_en", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Count down from 0; prescaler must have been cleared by reset.
        ud = 1'b1;
        edge_step();
        chk_all("down_1", 9, 1, 0, 1, 0, 0);
        edge_step();
        chk_all("down_2", 8, 0, 0, 1, 0, 0);
        edge_step();
        chk_all("down_3", 7, 0, 0, 1, 9, 1);

        // Saturate at the top: load 8 then step up three times.
        en   = 1'b0;
        load = 1'b1;
        d    = 4'd8;
        edge_step();
        chk_all("load8", 8, 0, 8, 0, 8, 0);
        load = 1'b0;
        en   = 1'b1;
        ud   = 1'b0;
        edge_step();
        chk_all("sat_up_1", 9, 0, 9, 0, 8, 0);
        edge_step();
        chk_all("sat_up_2", 0, 1, 9, 1, 8, 0);
        edge_step();
        chk_all("sat_up_3", 1, 0, 9, 1, 9, 0);

        // Prescaler holds while en=0.
        en   = 1'b0;
        load = 1'b1;
        d    = 4'd0;
        edge_step();
        chk_all("load0", 0, 0, 0, 0, 0, 0);
        load = 1'b0;
        en   = 1'b1;
        edge_step();
        chk_all("pre_en_1", 1, 0, 1, 0, 0, 0);
        edge_step();
        chk_all("pre_en_2", 2, 0, 2, 0, 0, 0);
        en = 1'b0;
        edge_step();
        chk_all("pre_hold_1", 2, 0, 2, 0, 0, 0);
        edge_step();
        chk_all("pre_hold_2", 2, 0, 2, 0, 0, 0);
        en = 1'b1;
        edge_step();
        chk_all("pre_en_3", 3, 0, 3, 0, 1, 0);
        edge_step();
        chk_all("pre_en_4", 4, 0, 4, 0, 1, 0);
        edge_step();
        chk_all("pre_en_5", 5, 0, 5, 0, 1, 0);
        edge_step();
        chk_all("pre_en_6", 6, 0, 6, 0, 2, 0);

        // Load with en=1 and d above MAX clamps and clears the prescaler.
        edge_step();
        chk_all("pre_before_load", 7, 0, 7, 0, 2, 0);
        load = 1'b1;
        d    = 4'd15;
        edge_step();
        chk_all("load15_clamp", 9, 0, 9, 0, 9, 0);
        load = 1'b0;
        edge_step();
        chk_all("after_load_1", 0, 1, 9, 1, 9, 0);
        edge_step();
        chk_all("after_load_2", 1, 0, 9, 1, 9, 0);
        edge_step();
        chk_all("after_load_3", 2, 0, 9, 1, 0, 1);

        // Load boundary values.
        load = 1'b1;
        d    = 4'd10;
        edge_step();
        chk_all("load10_clamp", 9, 0, 9, 0, 9, 0);
        d = 4'd9;
        edge_step();
        chk_all("load9", 9, 0, 9, 0, 9, 0);

        // Load and reset together: reset wins.
        d = 4'd5;
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("load_vs_reset", 0, 0, 0, 0, 0, 0);
        edge_step();
        chk_all("load_vs_reset_edge", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        edge_step();
        chk_all("load5_after_reset", 5, 0, 5, 0, 5, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
